fifo_rd_pix_packer: RTL and testbench

- Read-side consumer of the dual-clock byte FIFO; runs entirely in the FIFO read clock domain.
- Pops 8-bit bytes from the FIFO read port and packs every BYTES_PER_PIX bytes into one pixel word.
- Presents pixels on a valid/ready stream with end-of-line and start-of-line markers for the downstream video-out stage.

---
 rtl/fifo_rd_pix_packer.sv | 131 +++++++++++++
 tb/tb_fifo_rd_pix_packer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_pix_packer.sv
// Read-side byte-to-pixel packer for the dual-clock byte FIFO.
// Pops bytes, packs them MSB-first into pixels, and streams them with line markers.
module fifo_rd_pix_packer #(
    parameter int BYTES_PER_PIX = 3,
    parameter int LINE_PIX      = 640,
    parameter int CNT_W         = 10
) (
    input  logic                       clk_r,
    input  logic                       rst,
    input  logic                       run,
    input  logic                       sync_clr,
    input  logic                       empty,
    output logic                       en_r,
    input  logic [7:0]                 data_r,
    output logic [8*BYTES_PER_PIX-1:0] pix_data,
    output logic                       pix_valid,
    input  logic                       pix_ready,
    output logic                       pix_sol,
    output logic                       pix_eol,
    output logic [CNT_W-1:0]           pix_cnt
);

    localparam int PW = 8 * BYTES_PER_PIX;
    localparam int BW = $clog2(BYTES_PER_PIX);
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(LINE_PIX - 1);

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

    state_t          state_q;
    logic [BW-1:0]   held_q, held_d;
    logic            pend_q, pend_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   data_q, data_d;
    logic            valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic last_in;
    logic req_last;
    logic slot_free;
    logic rd;
    logic capture;
    logic xfer;
    int   occ;

    // A final byte landing this cycle frees the accumulator for the next pixel.
    always_comb begin
        last_in   = pend_q && (int'(held_q) == BYTES_PER_PIX - 1);
        occ       = last_in ? 0 : int'(held_q) + int'(pend_q);
        req_last  = (occ == BYTES_PER_PIX - 1);
        slot_free = !valid_q || pix_ready;
        rd        = (state_q == FETCH) && !empty && !sync_clr
                    && (occ < BYTES_PER_PIX)
                    && (!req_last || slot_free);
        capture   = pend_q && !sync_clr;
        xfer      = valid_q && pix_ready;
    end

    always_comb begin
        held_d  = held_q;
        acc_d   = acc_q;
        data_d  = data_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        pend_d  = rd;
        if (sync_clr) begin
            held_d  = '0;
            acc_d   = '0;
            data_d  = '0;
            valid_d = 1'b0;
            cnt_d   = '0;
        end else begin
            if (xfer) begin
                valid_d = 1'b0;
                cnt_d   = (cnt_q == LAST_PIX) ? '0 : cnt_q + 1'b1;
            end
            if (capture && last_in) begin
                data_d  = {acc_q[PW-1:8], data_r};
                valid_d = 1'b1;
                acc_d   = '0;
                held_d  = '0;
            end else if (capture) begin
                acc_d  = acc_q | (PW'(data_r)
                         << (8 * (BYTES_PER_PIX - 1 - int'(held_q))));
                held_d = held_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_r or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            held_q  <= '0;
            pend_q  <= 1'b0;
            acc_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (run && !sync_clr)
                        state_q <= FETCH;
                end
                FETCH: begin
                    if (sync_clr)
                        state_q <= run ? FETCH : IDLE;
                    else if (rd && req_last && !run)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            held_q  <= held_d;
            pend_q  <= pend_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign en_r      = rd;
    assign pix_data  = data_q;
    assign pix_valid = valid_q;
    assign pix_cnt   = cnt_q;
    assign pix_sol   = valid_q && (cnt_q == '0);
    assign pix_eol   = valid_q && (cnt_q == LAST_PIX);

endmodule

// File: tb/tb_fifo_rd_pix_packer.sv
// Bench for fifo_rd_pix_packer: FIFO model, pixel scoreboard and directed scenarios.
// Expected pixels are packed from the pushed bytes; the line position is modelled separately.
module tb_fifo_rd_pix_packer;

    localparam int BPP = 3;
    localparam int LP  = 4;
    localparam int CW  = 10;

    logic clk_r = 1'b0;
    logic rst = 1'b0;
    logic run = 1'b0;
    logic sync_clr = 1'b0;
    logic pix_ready = 1'b1;
    logic empty, en_r, pix_valid, pix_sol, pix_eol;
    logic [7:0] data_r = 8'h00;
    logic [8*BPP-1:0] pix_data;
    logic [CW-1:0] pix_cnt;

    fifo_rd_pix_packer #(
        .BYTES_PER_PIX(BPP),
        .LINE_PIX(LP),
        .CNT_W(CW)
    ) dut (
        .clk_r(clk_r),
        .rst(rst),
        .run(run),
        .sync_clr(sync_clr),
        .empty(empty),
        .en_r(en_r),
        .data_r(data_r),
        .pix_data(pix_data),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .pix_sol(pix_sol),
        .pix_eol(pix_eol),
        .pix_cnt(pix_cnt)
    );

    always #5 clk_r = ~clk_r;

    logic [7:0] mem [256];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign empty = (rd_ptr == wr_ptr);

    always @(posedge clk_r) begin
        if (en_r && !empty) begin
            data_r <= mem[rd_ptr[7:0]];
            rd_ptr <= rd_ptr + 1;
        end
    end

    int checks = 0;
    int errors = 0;
    logic [23:0] exp_q [$];
    int log_cnt [$];
    int log_sol [$];
    int log_eol [$];
    int m_cnt = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[7:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    function automatic logic [23:0] pack(input int b0, input int b1, input int b2);
        return 24'(b0 * 65536 + b1 * 256 + b2);
    endfunction

    task automatic push_pix(input int b0, input int b1, input int b2);
        push(8'(b0));
        push(8'(b1));
        push(8'(b2));
        exp_q.push_back(pack(b0, b1, b2));
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_r);
            #3;
            if (exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        check(name, 32'(done), 32'd1);
    endtask

    // Scoreboard: every transfer, hold-stability and FIFO read legality.
    logic pv = 1'b0, pr = 1'b0, ps = 1'b0;
    logic [23:0] pd = '0;
    logic [CW-1:0] pc = '0;

    initial begin
        forever begin
            @(negedge clk_r);
            #2;
            if (rst) begin
                m_cnt = 0;
                pv = 1'b0;
            end else begin
                check("en_r_while_empty", 32'(en_r & empty), 32'd0);
                if (pv && !pr && !ps) begin
                    check("hold_valid", 32'(pix_valid), 32'd1);
                    check("hold_data", 32'(pix_data), 32'(pd));
                    check("hold_cnt", 32'(pix_cnt), 32'(pc));
                end
                if (pix_valid && pix_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_pixel", 32'(pix_data), 32'hFFFFFFFF);
                    end else begin
                        check("pix_data", 32'(pix_data), 32'(exp_q.pop_front()));
                    end
                    check("pix_cnt", 32'(pix_cnt), 32'(m_cnt));
                    check("pix_sol", 32'(pix_sol), 32'(m_cnt == 0));
                    check("pix_eol", 32'(pix_eol), 32'(m_cnt == LP - 1));
                    log_cnt.push_back(int'(pix_cnt));
                    log_sol.push_back(int'(pix_sol));
                    log_eol.push_back(int'(pix_eol));
                    m_cnt = (m_cnt + 1) % LP;
                end
                if (sync_clr) m_cnt = 0;
                pv = pix_valid;
                pr = pix_ready;
                ps = sync_clr;
                pd = pix_data;
                pc = pix_cnt;
            end
        end
    end

    int base;
    bit found;
    int exp_c [5] = '{0, 1, 2, 3, 0};
    int exp_s [5] = '{1, 0, 0, 0, 1};
    int exp_e [5] = '{0, 0, 0, 1, 0};

    initial begin
        #1 rst = 1'b1;
        #1;
        check("rst_en_r", 32'(en_r), 32'd0);
        check("rst_valid", 32'(pix_valid), 32'd0);
        check("rst_data", 32'(pix_data), 32'd0);
        check("rst_sol_eol", 32'({pix_sol, pix_eol}), 32'd0);
        check("rst_cnt", 32'(pix_cnt), 32'd0);
        repeat (2) @(negedge clk_r);
        rst = 1'b0;

        // First pixel latency
        @(negedge clk_r);
        push_pix('h11, 'h22, 'h33);
        run = 1'b1;
        @(posedge clk_r);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_r);
            #1;
            check($sformatf("lat_en_r_c%0d", c), 32'(en_r), 32'(c < 3));
            if (c == 3) check("lat_valid_c3", 32'(pix_valid), 32'd0);
        end
        check("lat_valid_c4", 32'(pix_valid), 32'd1);
        check("lat_data_c4", 32'(pix_data), 32'h112233);
        check("lat_sol_c4", 32'(pix_sol), 32'd1);
        check("lat_cnt_c4", 32'(pix_cnt), 32'd0);

        // Backpressure
        base = rd_ptr;
        push_pix(1, 2, 3);
        push_pix(4, 5, 6);
        push_pix(7, 8, 9);
        push_pix(10, 11, 12);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_r);
            #1;
            if (pix_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("bp_first_seen", 32'(found), 32'd1);
        pix_ready = 1'b0;
        check("bp_first_data", 32'(pix_data), 32'h010203);
        repeat (10) @(negedge clk_r);
        #1;
        check("bp_bytes_read", 32'(rd_ptr - base), 32'd5);
        check("bp_held_data", 32'(pix_data), 32'h010203);
        check("bp_held_valid", 32'(pix_valid), 32'd1);
        pix_ready = 1'b1;
        wait_drain("bp_drain");

        check("line_log_size", 32'(log_cnt.size()), 32'd5);
        for (int i = 0; i < 5 && i < log_cnt.size(); i++) begin
            check($sformatf("line_cnt_%0d", i), 32'(log_cnt[i]), 32'(exp_c[i]));
            check($sformatf("line_sol_%0d", i), 32'(log_sol[i]), 32'(exp_s[i]));
            check($sformatf("line_eol_%0d", i), 32'(log_eol[i]), 32'(exp_e[i]));
        end

        // Empty gap after two bytes
        @(negedge clk_r);
        push(8'hD1);
        push(8'hD2);
        exp_q.push_back(pack('hD1, 'hD2, 'hD3));
        repeat (2) @(negedge clk_r);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_r);
            #1;
            check($sformatf("gap_en_r_%0d", i), 32'(en_r), 32'd0);
            check($sformatf("gap_valid_%0d", i), 32'(pix_valid), 32'd0);
        end
        check("gap_no_overread", 32'(rd_ptr), 32'(wr_ptr));
        @(negedge clk_r);
        push(8'hD3);
        wait_drain("gap_drain");

        // Realign with a byte in flight
        @(negedge clk_r);
        push(8'h55);
        push(8'h66);
        #1;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (en_r) begin
                found = 1'b1;
                break;
            end
            @(negedge clk_r);
            #1;
        end
        check("sync_read_seen", 32'(found), 32'd1);
        repeat (2) @(negedge clk_r);
        sync_clr = 1'b1;
        #1;
        check("sync_en_r", 32'(en_r), 32'd0);
        @(negedge clk_r);
        sync_clr = 1'b0;
        #1;
        check("sync_valid", 32'(pix_valid), 32'd0);
        check("sync_cnt", 32'(pix_cnt), 32'd0);
        push_pix('hAA, 'hBB, 'hCC);
        wait_drain("sync_drain");
        check("sync_pix_cnt", log_cnt.size() > 0 ? 32'(log_cnt[$]) : 32'hFFFFFFFF, 32'd0);

        // Asynchronous reset mid-pixel
        @(negedge clk_r);
        pix_ready = 1'b0;
        push(8'h41);
        push(8'h42);
        push(8'h43);
        push(8'h31);
        push(8'h32);
        repeat (8) @(negedge clk_r);
        #1;
        check("prerst_valid", 32'(pix_valid), 32'd1);
        check("prerst_data", 32'(pix_data), 32'h414243);
        check("prerst_cnt", 32'(pix_cnt), 32'd1);
        check("prerst_bytes", 32'(rd_ptr), 32'(wr_ptr));
        @(posedge clk_r);
        #3;
        rst = 1'b1;
        #1;
        check("arst_en_r", 32'(en_r), 32'd0);
        check("arst_valid", 32'(pix_valid), 32'd0);
        check("arst_data", 32'(pix_data), 32'd0);
        check("arst_sol_eol", 32'({pix_sol, pix_eol}), 32'd0);
        check("arst_cnt", 32'(pix_cnt), 32'd0);
        repeat (2) @(negedge clk_r);
        rst = 1'b0;
        pix_ready = 1'b1;
        push_pix('h51, 'h52, 'h53);
        wait_drain("rst_drain");
        check("rst_pix_cnt", log_cnt.size() > 0 ? 32'(log_cnt[$]) : 32'hFFFFFFFF, 32'd0);
        check("rst_pix_sol", log_sol.size() > 0 ? 32'(log_sol[$]) : 32'hFFFFFFFF, 32'd1);

        repeat (3) @(negedge clk_r);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
